fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Credit-based round-robin write arbiter that shares one `Syn_FIFO` write port among `N_REQ` producers. It accepts beats over per-requester valid/ready handshakes and tags each beat with its source ID. Packets are kept atomic: a grant is held until the beat marked `last` is accepted. It also tracks free FIFO entries with a credit counter, so it never issues a write the FIFO would drop, despite the FIFO's registered `wr_en` and lagging `full`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, payload width per beat
- `ADDR_WIDTH`, 8, FIFO address width; FIFO depth D = 2^ADDR_WIDTH
- `ID_WIDTH`, 2, source tag width; must satisfy 2^ID_WIDTH >= N_REQ
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  N_REQ  per-requester beat valid
- `req_last`  in  N_REQ  beat is last of packet
- `req_data`  in  N_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  N_REQ  beat accepted when valid&ready at a clk edge
- `fifo_wr_en`  out  1  to FIFO `wr_en`, registered
- `fifo_data_in`  out  ID_WIDTH+DATA_WIDTH  to FIFO `data_in`, {id, payload}, registered
- `rd_credit`  in  1  one-cycle pulse per FIFO read actually performed (consumer's `rd_en` while FIFO non-empty)
- `credits`  out  ADDR_WIDTH+1  free FIFO entries as seen by the arbiter
- `grant_id`  out  ID_WIDTH  current/last owner
- `busy`  out  1  1 in LOCK state
- `overflow_err`  out  1  sticky, `rd_credit` received with credits == D

## Operation
- **States:** IDLE and LOCK. An rr pointer `ptr` (0..N_REQ-1) gives priority.
- **IDLE:**
  - If credits != 0, the winner is the first requester with `req_valid` set, searching from `ptr` upward with wrap. `req_ready` is 1 for the winner only, combinationally.
  - If credits == 0, all ready are 0.
  - On accept with last=0: go to LOCK, owner = winner, `grant_id` = winner.
  - On accept with last=1: stay in IDLE, `ptr` = winner+1 mod N_REQ.
- **LOCK:**
  - `req_ready[owner]` = (credits != 0); all other ready = 0, regardless of their valid.
  - On owner accept with last=1: go to IDLE, `ptr` = owner+1 mod N_REQ.
- **Accept at edge t:** `fifo_wr_en` = 1 and `fifo_data_in` = {id, data} during cycle t+1; otherwise `fifo_wr_en` = 0 and `fifo_data_in` holds its value.
- **Credits:** `credits_next` = credits − accept + `rd_credit`, where accept and `rd_credit` each count 0/1.
  - Range is 0..D.
  - `rd_credit` at credits == D: credits holds D and `overflow_err` sets.
- **Ready rule:** ready never asserts to a requester whose valid is 0. Ready is 0 while `rst_n` is low.
- **Reset sharing:** `rst_n` must be shared with the FIFO. Reset mid-packet discards the lock; beats already written remain the FIFO's concern, and the FIFO is reset with it.

## Timing
- **Reset values:**
  - `fifo_wr_en` = 0, `fifo_data_in` = 0
  - credits = D
  - `grant_id` = 0, `busy` = 0, `overflow_err` = 0
  - state IDLE, `ptr` = 0
- **Throughput:** one beat per cycle sustained while credits > 0.
- **Latency:**
  - Accept edge t → `fifo_wr_en` high in t+1.
  - FIFO registers `wr_en` internally, so the entry is written at edge t+2.
- **Credit timing:**
  - A credit consumed at the accept edge is visible next cycle.
  - `rd_credit` at edge t frees the slot at the FIFO's edge t+1. A write issued from a credit returned at t reaches FIFO memory at t+2 at the earliest, so it is safe.
- **Arbitration:** an IDLE→grant decision is made in the same cycle as the request. No idle bubble between back-to-back single-beat packets from different requesters.

## Test plan
- **Reset:** after reset with `ADDR_WIDTH` = 8 → credits = 256, `fifo_wr_en` = 0, `req_ready` = 0000 with `req_valid` = 0000, `overflow_err` = 0.
- **Round-robin fairness:** `req_valid` = 1111 held, all `last` = 1 → accept order 0,1,2,3,0,1,…. `fifo_wr_en` is high every cycle starting one cycle after the first accept, and `fifo_data_in`[9:8] follows 0,1,2,3.
- **Packet lock:** req1 sends a 3-beat packet with `last` on the 3rd beat, while req2 is valid throughout → `req_ready[2]` = 0 for 3 cycles and `busy` = 1. req2 is accepted the cycle after req1's last beat, then `ptr` = 2.
- **Credit exhaustion:** `ADDR_WIDTH` = 2, req0 streams 6 beats, no `rd_credit` → exactly 4 accepted, credits = 0, ready low. A single `rd_credit` pulse gives credits = 1 and exactly one more beat accepted next cycle.
- **Simultaneous events:** at credits = 1, accept and `rd_credit` in the same cycle → credits stays 1. At credits = 0, `rd_credit` alone → credits = 1.
- **Overflow:** `rd_credit` pulsed at credits = D → credits = D and `overflow_err` = 1, staying set until `rst_n` is asserted.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin, packet-atomic write arbiter that shares one FIFO write port
// among N_REQ producers. Each accepted beat is tagged with its source ID.
// A credit counter tracks free FIFO entries so that no write is issued that
// the FIFO would drop.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset (shared with FIFO)
//   req_valid       per-requester beat valid
//   req_last        per-requester end-of-packet marker
//   req_data        packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready       per-requester ready (combinational)
//   fifo_wr_en      registered write enable to the FIFO
//   fifo_data_in    registered {id, payload} to the FIFO
//   rd_credit       one pulse per FIFO read actually performed
//   credits         free FIFO entries as seen by the arbiter (0..D)
//   grant_id        current / most recent owner
//   busy            high while a multi-beat packet holds the grant
//   overflow_err    sticky: rd_credit seen while credits == D
//
// state  | meaning
// IDLE   | no packet in flight, round-robin pick from ptr each cycle
// LOCK   | multi-beat packet in flight, only the owner may transfer
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_in,
    input  logic                           rd_credit,
    output logic [ADDR_WIDTH:0]            credits,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy,
    output logic                           overflow_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic [ADDR_WIDTH:0]  DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(N_REQ - 1);
    localparam logic [N_REQ-1:0]     ONE_HOT = N_REQ'(1);

    logic [0:0]                     state_q, state_d;
    logic [ID_WIDTH-1:0]            ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]            owner_q, owner_d;
    logic [ADDR_WIDTH:0]            credits_q, credits_d;
    logic                           wr_en_q, wr_en_d;
    logic [ID_WIDTH+DATA_WIDTH-1:0] data_q, data_d;
    logic                           ovf_q, ovf_d;

    logic                           win_found;
    logic [ID_WIDTH-1:0]            win_id;
    logic [ID_WIDTH-1:0]            sel_id;
    logic                           grant_ok;
    logic                           accept;
    logic                           acc_last;
    logic [ID_WIDTH-1:0]            next_ptr;
    int                             idx;

    // First valid requester searching upward from ptr, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        sel_id   = (state_q == S_IDLE) ? win_id : owner_q;
        // Ready is only offered to a requester that is actually valid.
        grant_ok = (credits_q != '0) && rst_n &&
                   ((state_q == S_IDLE) ? win_found : req_valid[owner_q]);
        req_ready = grant_ok ? (ONE_HOT << sel_id) : '0;
        accept    = grant_ok;
        acc_last  = req_last[sel_id];
        next_ptr  = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wr_en_d   = accept;
        data_d    = data_q;
        credits_d = credits_q;
        ovf_d     = ovf_q;

        if (accept) begin
            data_d  = {sel_id, req_data[sel_id*DATA_WIDTH +: DATA_WIDTH]};
            owner_d = sel_id;
            if (acc_last) begin
                state_d = S_IDLE;
                ptr_d   = next_ptr;
            end else begin
                state_d = S_LOCK;
            end
        end

        // Reads can only free entries that were written, so a credit at
        // full count is an upstream error; saturate and flag it.
        if (rd_credit && credits_q == DEPTH) ovf_d = 1'b1;

        case ({accept, rd_credit})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = (credits_q == DEPTH) ? credits_q : credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            credits_q <= DEPTH;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign credits      = credits_q;
    assign grant_id     = owner_q;
    assign busy         = (state_q == S_LOCK);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration,
// credit and output-register rules.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int IW = 2;
    localparam int D  = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_last = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_wr_en;
    logic [IW+DW-1:0]  fifo_data_in;
    logic              rd_credit = 1'b0;
    logic [AW:0]       credits;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              overflow_err;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .rd_credit(rd_credit), .credits(credits),
        .grant_id(grant_id), .busy(busy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_lock;
    int          m_owner, m_ptr, m_cred, m_grant;
    bit          m_ovf, m_wr;
    int          m_data;
    int          last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_owner = 0; m_ptr = 0; m_cred = D; m_grant = 0;
        m_ovf = 0; m_wr = 0; m_data = 0; last_acc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '1; req_last = '1; rd_credit = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rst_cred", 32'(credits), D);
        check("rst_wr", 32'(fifo_wr_en), 0);
        check("rst_data", 32'(fifo_data_in), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow_err), 0);
        check("rst_ready_idle", 32'(req_ready), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, check current-cycle outputs, advance model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input bit rd);
        int exp_ready;
        int id;
        int old;
        @(negedge clk);
        req_valid = v; req_last = l; rd_credit = rd;
        req_data  = 32'($urandom);
        #1;
        exp_ready = 0;
        id = -1;
        if (m_cred > 0) begin
            if (m_lock) begin
                if (v[m_owner]) id = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (id < 0 && v[(m_ptr + k) % N]) id = (m_ptr + k) % N;
            end
        end
        if (id >= 0) exp_ready = 1 << id;
        check("ready", 32'(req_ready), exp_ready);
        check("credits", 32'(credits), m_cred);
        check("wr_en", 32'(fifo_wr_en), m_wr);
        check("data", 32'(fifo_data_in), m_data);
        check("busy", 32'(busy), m_lock);
        check("grant", 32'(grant_id), m_grant);
        check("ovf", 32'(overflow_err), m_ovf);

        last_acc = id;
        old = m_cred;
        if (rd && old == D) m_ovf = 1;
        if (id >= 0) begin
            m_wr    = 1;
            m_data  = (id << DW) | int'(req_data[id*DW +: DW]);
            m_grant = id;
            m_owner = id;
            if (l[id]) begin
                m_lock = 0;
                m_ptr  = (id + 1) % N;
            end else begin
                m_lock = 1;
            end
        end else begin
            m_wr = 0;
        end
        m_cred = old - (id >= 0 ? 1 : 0) + (rd ? 1 : 0);
        if (m_cred > D) m_cred = D;
    endtask

    initial begin
        int accs;
        model_reset();
        do_reset();

        // Round-robin fairness, all valid, single-beat packets.
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b1111, i > 0);
            check("rr_order", 32'(last_acc), i % N);
            if (i > 0) begin
                check("rr_wr", 32'(fifo_wr_en), 1);
                check("rr_id", 32'(fifo_data_in[IW+DW-1:DW]), (i - 1) % N);
            end
        end

        // Packet lock: req1 three beats, req2 waiting.
        step(4'b0110, 4'b0000, 1'b1);
        check("lk_acc0", 32'(last_acc), 1);
        check("lk_r2_0", 32'(req_ready[2]), 0);
        step(4'b0110, 4'b0000, 1'b1);
        check("lk_acc1", 32'(last_acc), 1);
        check("lk_r2_1", 32'(req_ready[2]), 0);
        check("lk_busy1", 32'(busy), 1);
        check("lk_grant", 32'(grant_id), 1);
        step(4'b0110, 4'b0010, 1'b1);
        check("lk_acc2", 32'(last_acc), 1);
        check("lk_r2_2", 32'(req_ready[2]), 0);
        check("lk_busy2", 32'(busy), 1);
        step(4'b0111, 4'b0111, 1'b1);
        check("lk_ptr2", 32'(last_acc), 2);
        check("lk_busy3", 32'(busy), 0);

        // Credit exhaustion with D entries.
        do_reset();
        accs = 0;
        for (int i = 0; i < 6; i++) begin
            step(4'b0001, 4'b0001, 1'b0);
            if (last_acc >= 0) accs++;
        end
        check("ex_accs", 32'(accs), D);
        check("ex_cred0", 32'(credits), 0);
        check("ex_ready0", 32'(req_ready), 0);
        step(4'b0001, 4'b0001, 1'b1);
        check("ex_noacc", 32'(last_acc + 1), 0);
        step(4'b0001, 4'b0001, 1'b0);
        check("ex_cred1", 32'(credits), 1);
        check("ex_oneacc", 32'(last_acc), 0);
        step(4'b0001, 4'b0001, 1'b0);
        check("ex_stall", 32'(req_ready), 0);

        // Simultaneous accept and credit return.
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0001, 4'b0001, 1'b1);
        check("sim_cred1", 32'(credits), 1);
        check("sim_acc", 32'(last_acc), 0);
        step(4'b0000, 4'b0000, 1'b0);
        check("sim_hold", 32'(credits), 1);

        // Overflow: credit return while full.
        do_reset();
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b0);
        check("ov_cred", 32'(credits), D);
        check("ov_flag", 32'(overflow_err), 1);
        step(4'b0011, 4'b0011, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check("ov_sticky", 32'(overflow_err), 1);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] v, l;
            bit rd;
            v  = N'($urandom);
            l  = N'($urandom) | N'($urandom);
            rd = (m_cred < D) && ($urandom_range(0, 1) == 1);
            step(v, l, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
